// File: rtl/qspi_multi_ce_engine_if.sv
// Bus bundle for qspi_multi_ce_engine.
// Groups the byte request/response handshake and the shared QSPI pad signals.
//   slave  : the engine (consumes requests and sio_i, drives responses and pads)
//   master : the requesting controller plus the pad/device side
interface qspi_multi_ce_engine_if #(
   parameter int NUM_CE    = 2,
   parameter int DIV_WIDTH = 4
);
   localparam int CE_W = (NUM_CE > 1) ? $clog2(NUM_CE) : 1;

   logic [DIV_WIDTH-1:0] div;
   logic                 req_valid;
   logic                 req_ready;
   logic [CE_W-1:0]      req_ce;
   logic                 req_quad;
   logic                 req_dir;
   logic [7:0]           req_wdata;
   logic                 req_last;
   logic                 rsp_valid;
   logic [7:0]           rsp_rdata;
   logic [NUM_CE-1:0]    ce_n;
   logic [NUM_CE-1:0]    sclk;
   logic [3:0]           sio_o;
   logic [3:0]           sio_i;
   logic [3:0]           sio_oe;
   logic                 busy;

   modport slave (
      input  div, req_valid, req_ce, req_quad, req_dir, req_wdata, req_last, sio_i,
      output req_ready, rsp_valid, rsp_rdata, ce_n, sclk, sio_o, sio_oe, busy
   );

   modport master (
      output div, req_valid, req_ce, req_quad, req_dir, req_wdata, req_last, sio_i,
      input  req_ready, rsp_valid, rsp_rdata, ce_n, sclk, sio_o, sio_oe, busy
   );
endinterface

// File: rtl/qspi_multi_ce_engine.sv
// Byte-transfer engine driving one shared 4-lane SIO bus to NUM_CE devices,
// each with its own active-low CE and its own mode-0 SCLK.
// Ports:
//   clk    system clock
//   reset  synchronous active-high reset
//   bus    qspi_multi_ce_engine_if.slave: div, req_* handshake, rsp_* response,
//          ce_n/sclk per device, sio_o/sio_i/sio_oe pads, busy
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | all CE high, ready for a request
// SHIFT   | byte in flight, SCLK toggling every H = div+1 cycles
// HOLD    | CE low, SCLK low, waiting for the next byte
// GAP     | all CE high for H cycles; pend selects SHIFT or IDLE after
module qspi_multi_ce_engine #(
   parameter int NUM_CE    = 2,
   parameter int DIV_WIDTH = 4
) (
   input logic                    clk,
   input logic                    reset,
   qspi_multi_ce_engine_if.slave  bus
);
   localparam int CE_W = (NUM_CE > 1) ? $clog2(NUM_CE) : 1;
   localparam logic [CE_W:0] NUM_CE_L = (CE_W+1)'(NUM_CE);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_HOLD  = 2'd2;
   localparam logic [1:0] S_GAP   = 2'd3;

   logic [1:0]           state;
   logic [DIV_WIDTH-1:0] div_q;
   logic [DIV_WIDTH-1:0] cnt;
   logic                 quad_q;
   logic                 dir_q;
   logic                 last_q;
   logic [CE_W-1:0]      ce_q;
   logic                 ce_on;
   logic                 pend;
   logic [3:0]           tog;
   logic                 sclk_q;
   logic [7:0]           sh;
   logic [7:0]           rx;
   logic                 rsp_valid_q;
   logic [7:0]           rsp_rdata_q;

   logic                 ready;
   logic                 accept;
   logic                 ce_ok;

   assign ready  = (state == S_IDLE) || (state == S_HOLD);
   assign accept = bus.req_valid && ready;
   assign ce_ok  = {1'b0, bus.req_ce} < NUM_CE_L;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         div_q       <= '0;
         cnt         <= '0;
         quad_q      <= 1'b0;
         dir_q       <= 1'b0;
         last_q      <= 1'b0;
         ce_q        <= '0;
         ce_on       <= 1'b0;
         pend        <= 1'b0;
         tog         <= '0;
         sclk_q      <= 1'b0;
         sh          <= '0;
         rx          <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         rsp_valid_q <= 1'b0;

         // Everything a byte needs is captured at accept, so a later div
         // change cannot disturb it; cnt doubles as the GAP length counter.
         if (accept) begin
            div_q  <= bus.div;
            cnt    <= bus.div;
            quad_q <= bus.req_quad;
            dir_q  <= bus.req_dir;
            last_q <= bus.req_last;
            sh     <= bus.req_wdata;
            tog    <= bus.req_quad ? 4'd3 : 4'd15;
            sclk_q <= 1'b0;
         end

         case (state)
            S_IDLE: begin
               if (accept) begin
                  if (ce_ok) begin
                     ce_q  <= bus.req_ce;
                     ce_on <= 1'b1;
                     state <= S_SHIFT;
                  end else begin
                     rsp_valid_q <= 1'b1;
                     rsp_rdata_q <= 8'hFF;
                  end
               end
            end

            S_SHIFT: begin
               if (cnt == '0) begin
                  cnt    <= div_q;
                  sclk_q <= ~sclk_q;
                  if (!sclk_q) begin
                     rx <= quad_q ? {rx[3:0], bus.sio_i} : {rx[6:0], bus.sio_i[1]};
                  end else begin
                     sh <= quad_q ? {sh[3:0], 4'b0000} : {sh[6:0], 1'b0};
                  end
                  if (tog == '0) begin
                     rsp_valid_q <= 1'b1;
                     rsp_rdata_q <= rx;
                     if (last_q) begin
                        ce_on <= 1'b0;
                        pend  <= 1'b0;
                        state <= S_GAP;
                     end else begin
                        state <= S_HOLD;
                     end
                  end else begin
                     tog <= tog - 1'b1;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

            S_HOLD: begin
               if (accept) begin
                  if (!ce_ok) begin
                     rsp_valid_q <= 1'b1;
                     rsp_rdata_q <= 8'hFF;
                     ce_on       <= 1'b0;
                     pend        <= 1'b0;
                     state       <= S_GAP;
                  end else if (bus.req_ce == ce_q) begin
                     state <= S_SHIFT;
                  end else begin
                     ce_on <= 1'b0;
                     ce_q  <= bus.req_ce;
                     pend  <= 1'b1;
                     state <= S_GAP;
                  end
               end
            end

            default: begin
               if (cnt == '0) begin
                  if (pend) begin
                     ce_on <= 1'b1;
                     cnt   <= div_q;
                     pend  <= 1'b0;
                     state <= S_SHIFT;
                  end else begin
                     state <= S_IDLE;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
         endcase
      end
   end

   logic [NUM_CE-1:0] ce_n_c;
   logic [NUM_CE-1:0] sclk_c;

   always_comb begin
      ce_n_c = '1;
      sclk_c = '0;
      for (int i = 0; i < NUM_CE; i++) begin
         if (ce_on && (ce_q == CE_W'(i))) begin
            ce_n_c[i] = 1'b0;
            sclk_c[i] = sclk_q;
         end
      end
   end

   logic       lanes_on;
   logic [3:0] oe_c;
   logic [3:0] out_c;

   // HOLD keeps the byte's lane direction so oe only moves while SCLK is low.
   assign lanes_on = (state == S_SHIFT) || (state == S_HOLD);

   always_comb begin
      oe_c  = 4'b0000;
      out_c = 4'b0000;
      if (lanes_on) begin
         if (quad_q) oe_c = dir_q ? 4'b1111 : 4'b0000;
         else        oe_c = 4'b0001;
      end
      if (state == S_SHIFT) begin
         if (quad_q) out_c = dir_q ? sh[7:4] : 4'b0000;
         else        out_c = {3'b000, sh[7]};
      end
   end

   assign bus.req_ready = ready;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.ce_n      = ce_n_c;
   assign bus.sclk      = sclk_c;
   assign bus.sio_o     = out_c;
   assign bus.sio_oe    = oe_c;
   assign bus.busy      = ce_on || (state == S_SHIFT) || ((state == S_GAP) && pend);
endmodule

// File: tb/tb_qspi_multi_ce_engine.sv
module tb_qspi_multi_ce_engine;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // Three devices so that an out-of-range index (3) is expressible on req_ce.
   qspi_multi_ce_engine_if #(.NUM_CE(3), .DIV_WIDTH(4)) bus ();
   qspi_multi_ce_engine #(.NUM_CE(3), .DIV_WIDTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic       loop;
   logic [3:0] sio_drive;
   assign bus.sio_i = loop ? {2'b00, bus.sio_o[0], 1'b0} : sio_drive;

   int vectors = 0;
   int miscompares = 0;
   int overlap = 0;
   int oe_bad = 0;
   logic [3:0] prev_oe = 4'b0000;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if ($countones(~bus.ce_n) > 1) overlap++;
      if ((bus.sio_oe !== prev_oe) && (bus.sclk !== 3'b000)) oe_bad++;
      prev_oe = bus.sio_oe;
   endtask

   task automatic send(input logic [1:0] ce, input logic q, input logic d,
                       input logic [7:0] w, input logic l, input logic [3:0] dv,
                       input string tag);
      bus.req_ce    = ce;
      bus.req_quad  = q;
      bus.req_dir   = d;
      bus.req_wdata = w;
      bus.req_last  = l;
      bus.div       = dv;
      bus.req_valid = 1'b1;
      chk({tag, "_ready"}, {31'd0, bus.req_ready}, 32'd1);
      step();
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (!(bus.busy === 1'b0 && bus.req_ready === 1'b1) && n < 60) begin
         step();
         n++;
      end
      chk({tag, "_idle_wait"}, {31'd0, (n < 60) ? 1'b1 : 1'b0}, 32'd1);
   endtask

   initial begin
      int rises, rsp_cyc, ce_low, ce_hi, other, r1, r2;
      logic prev_s;
      logic [7:0] got;

      reset = 1'b1;
      loop = 1'b0;
      sio_drive = 4'h0;
      bus.req_valid = 1'b0;
      bus.req_ce = '0;
      bus.req_quad = 1'b0;
      bus.req_dir = 1'b0;
      bus.req_wdata = 8'h00;
      bus.req_last = 1'b0;
      bus.div = 4'd0;
      step();
      step();
      reset = 1'b0;
      step();

      // reset values
      chk("rst_ce_n",  {29'd0, bus.ce_n}, 32'h7);
      chk("rst_sclk",  {29'd0, bus.sclk}, 32'h0);
      chk("rst_sio_o", {28'd0, bus.sio_o}, 32'h0);
      chk("rst_oe",    {28'd0, bus.sio_oe}, 32'h0);
      chk("rst_rspv",  {31'd0, bus.rsp_valid}, 32'h0);
      chk("rst_rdata", {24'd0, bus.rsp_rdata}, 32'h0);
      chk("rst_busy",  {31'd0, bus.busy}, 32'h0);
      chk("rst_ready", {31'd0, bus.req_ready}, 32'h1);

      // single mode, div=0, loopback sio0 -> sio1
      loop = 1'b1;
      send(2'd0, 1'b0, 1'b0, 8'hA5, 1'b1, 4'd0, "t1");
      rises = 0; rsp_cyc = 0; ce_low = 0; other = 0; prev_s = 1'b0; got = 8'h00;
      for (int c = 1; c <= 20; c++) begin
         if (c > 1) step();
         if (c == 1) begin
            chk("t1_ce_first", {29'd0, bus.ce_n}, 32'h6);
            chk("t1_oe_first", {28'd0, bus.sio_oe}, 32'h1);
         end
         if (bus.sclk[0] && !prev_s) rises++;
         prev_s = bus.sclk[0];
         if (bus.rsp_valid && rsp_cyc == 0) begin rsp_cyc = c; got = bus.rsp_rdata; end
         if (bus.ce_n == 3'b110) ce_low++;
         if (bus.sclk[2:1] != 2'b00) other++;
         if (c == 18) chk("t1_ready_after", {31'd0, bus.req_ready}, 32'h1);
      end
      chk("t1_rises", rises, 8);
      chk("t1_rsp_cyc", rsp_cyc, 17);
      chk("t1_rdata", {24'd0, got}, 32'hA5);
      chk("t1_ce_low_cycles", ce_low, 16);
      chk("t1_other_sclk", other, 0);

      // quad write 3C, held CE, then quad read returning 9,6; div=2 (H=3)
      loop = 1'b0;
      sio_drive = 4'h9;
      send(2'd0, 1'b1, 1'b1, 8'h3C, 1'b0, 4'd2, "t2w");
      ce_hi = 0;
      for (int c = 1; c <= 13; c++) begin
         if (c > 1) step();
         if (c == 1) begin
            chk("t2_sio_hi", {28'd0, bus.sio_o}, 32'h3);
            chk("t2_oe_w", {28'd0, bus.sio_oe}, 32'hF);
         end
         if (c == 7) chk("t2_sio_lo", {28'd0, bus.sio_o}, 32'hC);
         if (bus.ce_n[0]) ce_hi++;
      end
      chk("t2_w_rspv", {31'd0, bus.rsp_valid}, 32'h1);
      chk("t2_hold_busy", {31'd0, bus.busy}, 32'h1);
      send(2'd0, 1'b1, 1'b0, 8'h00, 1'b1, 4'd2, "t2r");
      for (int c = 1; c <= 13; c++) begin
         if (c > 1) step();
         if (c == 1) chk("t2_oe_r", {28'd0, bus.sio_oe}, 32'h0);
         if (c == 7) sio_drive = 4'h6;
         if (c < 13 && bus.ce_n[0]) ce_hi++;
      end
      chk("t2_r_rspv", {31'd0, bus.rsp_valid}, 32'h1);
      chk("t2_rdata", {24'd0, bus.rsp_rdata}, 32'h96);
      chk("t2_ce_glitch", ce_hi, 0);
      wait_idle("t2");

      // HOLD on ce0, then switch to ce1 with div=1 (H=2)
      send(2'd0, 1'b1, 1'b1, 8'h55, 1'b0, 4'd0, "t3a");
      for (int c = 2; c <= 5; c++) step();
      chk("t3_hold_rspv", {31'd0, bus.rsp_valid}, 32'h1);
      chk("t3_hold_ce", {29'd0, bus.ce_n}, 32'h6);
      send(2'd1, 1'b1, 1'b1, 8'hAA, 1'b1, 4'd1, "t3b");
      chk("t3_gap1", {29'd0, bus.ce_n}, 32'h7);
      step();
      chk("t3_gap2", {29'd0, bus.ce_n}, 32'h7);
      step();
      chk("t3_ce1_on", {29'd0, bus.ce_n}, 32'h5);
      wait_idle("t3");

      // reset at the 4th SCLK rising edge of a single-mode byte
      loop = 1'b1;
      send(2'd0, 1'b0, 1'b0, 8'hF0, 1'b1, 4'd0, "t4");
      rises = 0; prev_s = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         if (c > 1) step();
         if (bus.sclk[0] && !prev_s) rises++;
         prev_s = bus.sclk[0];
      end
      chk("t4_rises_before", rises, 4);
      reset = 1'b1;
      step();
      chk("t4_ce_n", {29'd0, bus.ce_n}, 32'h7);
      chk("t4_sclk", {29'd0, bus.sclk}, 32'h0);
      chk("t4_oe", {28'd0, bus.sio_oe}, 32'h0);
      chk("t4_rspv", {31'd0, bus.rsp_valid}, 32'h0);
      reset = 1'b0;
      step();
      chk("t4_ready", {31'd0, bus.req_ready}, 32'h1);
      other = 0;
      for (int c = 0; c < 20; c++) begin
         step();
         if (bus.rsp_valid) other++;
      end
      chk("t4_no_rsp", other, 0);

      // out-of-range device index
      send(2'd3, 1'b0, 1'b0, 8'h12, 1'b1, 4'd0, "t5");
      chk("t5_rspv", {31'd0, bus.rsp_valid}, 32'h1);
      chk("t5_rdata", {24'd0, bus.rsp_rdata}, 32'hFF);
      chk("t5_ce_n", {29'd0, bus.ce_n}, 32'h7);
      chk("t5_sclk", {29'd0, bus.sclk}, 32'h0);
      chk("t5_oe", {28'd0, bus.sio_oe}, 32'h0);
      step();
      chk("t5_rspv_drop", {31'd0, bus.rsp_valid}, 32'h0);
      chk("t5_rdata_hold", {24'd0, bus.rsp_rdata}, 32'hFF);
      chk("t5_ready", {31'd0, bus.req_ready}, 32'h1);

      // div changed mid-byte has no effect until the next accept
      send(2'd2, 1'b0, 1'b0, 8'h81, 1'b1, 4'd0, "t6a");
      chk("t6_ce2", {29'd0, bus.ce_n}, 32'h3);
      rises = 0; rsp_cyc = 0; prev_s = 1'b0; got = 8'h00;
      for (int c = 1; c <= 18; c++) begin
         if (c > 1) step();
         if (c == 3) bus.div = 4'd7;
         if (bus.sclk[2] && !prev_s) rises++;
         prev_s = bus.sclk[2];
         if (bus.rsp_valid && rsp_cyc == 0) begin rsp_cyc = c; got = bus.rsp_rdata; end
      end
      chk("t6_rises", rises, 8);
      chk("t6_rsp_cyc", rsp_cyc, 17);
      chk("t6_rdata", {24'd0, got}, 32'h81);
      send(2'd1, 1'b1, 1'b1, 8'h5A, 1'b1, 4'd7, "t6b");
      r1 = 0; r2 = 0; rsp_cyc = 0; prev_s = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         if (c > 1) step();
         if (bus.sclk[1] && !prev_s) begin
            if (r1 == 0) r1 = c; else if (r2 == 0) r2 = c;
         end
         prev_s = bus.sclk[1];
         if (bus.rsp_valid && rsp_cyc == 0) rsp_cyc = c;
      end
      chk("t6_rise1", r1, 9);
      chk("t6_rise2", r2, 25);
      chk("t6_rsp_slow", rsp_cyc, 33);
      wait_idle("t6");

      chk("ce_overlap", overlap, 0);
      chk("oe_while_sclk_high", oe_bad, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
